// File: rtl/bcd_to_binary16.sv
// bcd_to_binary16: sequential 5-digit packed-BCD to 16-bit unsigned binary converter.
// Ports: clk/rst (async active-high); start + bcd[19:0] request; busy, one-cycle done,
//        binary[15:0], err_digit, overflow results (held until the next accepted start).
// Latency: valid data -> done 5 edges after the accepting edge; invalid digit -> done after accept.
module bcd_to_binary16 #(
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           binary,
    output logic                  err_digit,
    output logic                  overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [4*DIGITS-1:0] sh_q, sh_d;
    logic [16:0]         acc_q, acc_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [15:0]         bin_q, bin_d;
    logic                err_q, err_d;
    logic                ovf_q, ovf_d;

    logic [3:0]          digit;
    logic [16:0]         acc_nx;
    logic                bad_digit;

    // Digit selected by the counter; the counter starts at the MSD index.
    assign digit  = sh_q[{cnt_q, 2'b00} +: 4];
    // acc*10 + digit; 17 bits hold 99999 so nothing is truncated before the final check.
    assign acc_nx = (acc_q << 3) + (acc_q << 1) + {13'd0, digit};

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        bin_d   = bin_q;
        err_d   = err_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sh_d  = bcd;
                    bin_d = 16'h0000;
                    err_d = 1'b0;
                    ovf_d = 1'b0;
                    acc_d = 17'd0;
                    if (bad_digit) begin
                        // Reject immediately: no conversion cycles are spent.
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        cnt_d   = 3'd0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = 3'(DIGITS - 1);
                        busy_d  = 1'b1;
                        state_d = S_CONV;
                    end
                end
            end
            S_CONV: begin
                acc_d = acc_nx;
                if (cnt_q == 3'd0) begin
                    // Last digit consumed: saturate anything above 16 bits.
                    done_d  = 1'b1;
                    state_d = S_DONE;
                    if (acc_nx[16]) begin
                        bin_d = 16'hFFFF;
                        ovf_d = 1'b1;
                    end else begin
                        bin_d = acc_nx[15:0];
                    end
                end else begin
                    cnt_d  = cnt_q - 3'd1;
                    busy_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            acc_q   <= 17'd0;
            cnt_q   <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bin_q   <= 16'h0000;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bin_q   <= bin_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign binary    = bin_q;
    assign err_digit = err_q;
    assign overflow  = ovf_q;

endmodule
